// File: rtl/gf_pkg.sv
// gf_pkg: tower-field GF((2^4)^2) types, FSM states, latency constants and GF(2^2) helpers
package gf_pkg;
  localparam logic [7:0] GF8_ONE = 8'h11;
  localparam int LAT_ZERO = 1;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    INV  = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4,
    OUT  = 3'd5
  } state_t;
  typedef struct packed {
    logic [3:0] p;
    logic [1:0] a;
    logic       ah;
    logic       al;
    logic       aa;
  } opnd_t;
  function automatic int lat_cycles(input bit pipe_inv);
    return pipe_inv ? 5 : 4;
  endfunction
  function automatic logic [1:0] mul2s(input logic [1:0] x, input logic [1:0] y, input logic xs, input logic ys);
    return {(xs & ys) ^ (x[0] & y[0]), (x[1] & y[1]) ^ (x[0] & y[0])};
  endfunction
  function automatic logic [1:0] mul2(input logic [1:0] x, input logic [1:0] y);
    return mul2s(x, y, ^x, ^y);
  endfunction
  function automatic logic [1:0] sq2(input logic [1:0] x);
    return {x[1], x[1] ^ x[0]};
  endfunction
  function automatic logic [1:0] scl_w(input logic [1:0] x);
    return {x[1] ^ x[0], x[1]};
  endfunction
  function automatic logic [1:0] scl_w2(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction
endpackage

// File: rtl/gf_mul4_opnd.sv
// gf_mul4_opnd: builds the presummed multiplier operand {p, a, ah, al, aa} from p[3:0]
module gf_mul4_opnd import gf_pkg::*; (
  input  logic [3:0] p,
  output opnd_t      o
);
  assign o = {p, p[3:2] ^ p[1:0], ^p[3:2], ^p[1:0], ^p};
endmodule

// File: rtl/gf_prims_4.sv
// gf_prims_4: GF(2^4) multiply (presummed operands), square-scale by N=0x8, and inverse
module gf_mul_4 import gf_pkg::*; (
  input  opnd_t      a,
  input  opnd_t      b,
  output logic [3:0] y
);
  logic [1:0] hh, ll, ss;
  assign hh = mul2s(a.p[3:2], b.p[3:2], a.ah, b.ah);
  assign ll = mul2s(a.p[1:0], b.p[1:0], a.al, b.al);
  assign ss = mul2s(a.a, b.a, a.aa, b.aa);
  assign y  = {ss ^ ll, scl_w(hh) ^ ll};
endmodule

module gf_sq_scl_4 import gf_pkg::*; (
  input  logic [3:0] x,
  output logic [3:0] y
);
  logic [1:0] h;
  assign h = sq2(x[3:2]);
  assign y = {h ^ scl_w(sq2(x[1:0])), scl_w2(h)};
endmodule

module gf_inv_4 import gf_pkg::*; (
  input  logic [3:0] x,
  output logic [3:0] y
);
  logic [1:0] h, l, e;
  assign h = x[3:2];
  assign l = x[1:0];
  assign e = sq2(scl_w(sq2(h)) ^ mul2(h, l) ^ sq2(l));
  assign y = {mul2(e, h), mul2(e, h ^ l)};
endmodule

// File: rtl/gf_inv_8_seq.sv
// gf_inv_8_seq: multi-cycle GF(2^8) tower inverter sharing one gf_mul_4 behind valid/ready
module gf_inv_8_seq import gf_pkg::*; #(
  parameter bit PIPE_INV    = 1'b0,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);
  state_t     state;
  logic [7:0] x;
  logic [3:0] d, yh, di, inv_d, sq_d, p_a, p_b, m;
  opnd_t      o_a, o_b;
  logic       acc, zero_in;
  assign in_ready  = !rst && (state == IDLE || (state == OUT && out_ready));
  assign acc       = in_valid && in_ready;
  assign zero_in   = ZERO_BYPASS && in_data == 8'h00;
  assign out_valid = state == OUT;
  assign busy      = state != IDLE;
  assign p_a = state == M0 ? x[7:4] : (state == M1 || state == M2) ? di : 4'h0;
  assign p_b = (state == M0 || state == M1) ? x[3:0] : state == M2 ? x[7:4] : 4'h0;
  gf_mul4_opnd u_opnd_a (.p(p_a), .o(o_a));
  gf_mul4_opnd u_opnd_b (.p(p_b), .o(o_b));
  gf_mul_4     u_mul    (.a(o_a), .b(o_b), .y(m));
  gf_sq_scl_4  u_sq     (.x(x[7:4] ^ x[3:0]), .y(sq_d));
  gf_inv_4     u_inv    (.x(d), .y(inv_d));
  if (PIPE_INV) begin : g_pipe
    logic [3:0] di_q;
    always_ff @(posedge clk)
      di_q <= rst ? 4'h0 : state == INV ? inv_d : di_q;
    assign di = di_q;
  end else begin : g_comb
    assign di = inv_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x        <= 8'h00;
      d        <= 4'h0;
      yh       <= 4'h0;
      out_data <= 8'h00;
    end else begin
      case (state)
        IDLE, OUT: begin
          if (acc) begin
            x     <= in_data;
            state <= zero_in ? OUT : M0;
            if (zero_in) out_data <= 8'h00;
          end else if (state == OUT && out_ready) begin
            state <= IDLE;
          end
        end
        M0: begin
          d     <= sq_d ^ m;
          state <= PIPE_INV ? INV : M1;
        end
        INV: state <= M1;
        M1: begin
          yh    <= m;
          state <= M2;
        end
        M2: begin
          out_data <= {yh, m};
          state    <= OUT;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gf_inv_8_seq.sv
// tb_gf_inv_8_seq: scoreboard bench for gf_inv_8_seq in two configurations
module tb_gf_inv_8_seq;
  import gf_pkg::*;
  logic clk = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  localparam logic [1:0] M2T [16] = '{2'd0, 2'd0, 2'd0, 2'd0,
                                      2'd0, 2'd1, 2'd2, 2'd3,
                                      2'd0, 2'd2, 2'd3, 2'd1,
                                      2'd0, 2'd3, 2'd1, 2'd2};
  function automatic logic [1:0] m2(input logic [1:0] a, input logic [1:0] b);
    return M2T[{a, b}];
  endfunction
  function automatic logic [3:0] m4(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh, hl, lh, ll;
    hh = m2(a[3:2], b[3:2]);
    hl = m2(a[3:2], b[1:0]);
    lh = m2(a[1:0], b[3:2]);
    ll = m2(a[1:0], b[1:0]);
    return {hh ^ hl ^ lh, m2(2'd2, hh) ^ ll};
  endfunction
  function automatic logic [7:0] m8(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh, ll, cr;
    hh = m4(a[7:4], b[7:4]);
    ll = m4(a[3:0], b[3:0]);
    cr = m4(a[7:4], b[3:0]) ^ m4(a[3:0], b[7:4]);
    return {m4(hh, 4'h9) ^ m4(ll ^ cr, 4'h8), m4(hh ^ cr, 4'h8) ^ m4(ll, 4'h9)};
  endfunction
  function automatic logic [7:0] inv_ref(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int y = 1; y < 256; y++)
      if (m8(x, 8'(y)) == 8'h11) r = 8'(y);
    return r;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  for (genvar c = 0; c < 2; c++) begin : g_ch
    localparam bit PI  = (c == 1);
    localparam bit ZB  = (c == 0);
    localparam int LAT = PI ? 5 : 4;
    localparam int CH  = c;
    logic       rs, iv, ir, ov, ordy, bz;
    logic [7:0] id, od;
    logic       done = 1'b0;
    logic       seen = 1'b0;
    logic [7:0] q_x[$];
    logic [7:0] q_e[$];
    int         q_l[$];
    int         q_a[$];
    gf_inv_8_seq #(.PIPE_INV(PI), .ZERO_BYPASS(ZB)) u_dut (
      .clk(clk), .rst(rs), .in_valid(iv), .in_ready(ir), .in_data(id),
      .out_valid(ov), .out_ready(ordy), .out_data(od), .busy(bz)
    );
    always @(negedge clk) begin
      #2;
      if (ov) begin
        if (q_e.size() == 0) begin
          chk($sformatf("c%0d spurious out_valid data=%h", CH, od), 1, 0);
        end else begin
          if (!seen) begin
            chk($sformatf("c%0d latency x=%h", CH, q_x[0]), cyc - q_a[0], q_l[0]);
            if (q_x[0] != 8'h00) chk($sformatf("c%0d x*inv x=%h", CH, q_x[0]), int'(m8(q_x[0], od)), int'(GF8_ONE));
            seen = 1'b1;
          end
          chk($sformatf("c%0d data x=%h", CH, q_x[0]), int'(od), int'(q_e[0]));
          if (ordy) begin
            void'(q_x.pop_front());
            void'(q_e.pop_front());
            void'(q_l.pop_front());
            void'(q_a.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
    task automatic push(input logic [7:0] x, input logic [7:0] e);
      q_x.push_back(x);
      q_e.push_back(e);
      q_l.push_back((x == 8'h00 && ZB) ? 1 : LAT);
      q_a.push_back(cyc);
    endtask
    task automatic send(input logic [7:0] x, input logic [7:0] e);
      int t;
      @(negedge clk);
      iv = 1'b1;
      id = x;
      #1;
      t = 0;
      while (!ir && t < 100) begin
        @(negedge clk);
        #1;
        t++;
      end
      chk($sformatf("c%0d accept x=%h", CH, x), int'(ir), 1);
      if (ir) push(x, e);
    endtask
    task automatic idle();
      @(negedge clk);
      iv = 1'b0;
    endtask
    task automatic drain();
      int t;
      t = 0;
      while (q_e.size() != 0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("c%0d drain", CH), q_e.size(), 0);
    endtask
    initial begin
      int t;
      rs = 1'b1; iv = 1'b1; id = 8'h53; ordy = 1'b1;
      repeat (3) begin
        @(negedge clk);
        #1;
        chk($sformatf("c%0d rst in_ready", CH), int'(ir), 0);
        chk($sformatf("c%0d rst out_valid", CH), int'(ov), 0);
        chk($sformatf("c%0d rst busy", CH), int'(bz), 0);
      end
      rs = 1'b0; iv = 1'b0;
      @(negedge clk);
      #1;
      chk($sformatf("c%0d post-rst in_ready", CH), int'(ir), 1);
      chk($sformatf("c%0d post-rst busy", CH), int'(bz), 0);
      send(GF8_ONE, 8'h11);
      idle();
      drain();
      send(8'h00, 8'h00);
      send(8'h01, 8'hA0);
      send(8'h10, 8'h0A);
      send(8'hA0, 8'h01);
      send(8'h0A, 8'h10);
      idle();
      drain();
      for (int i = 0; i < 256; i++) send(8'(i), inv_ref(8'(i)));
      idle();
      drain();
      ordy = 1'b0;
      send(8'hB7, inv_ref(8'hB7));
      @(negedge clk);
      iv = 1'b1;
      id = 8'h53;
      t = 0;
      while (!ov && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("c%0d bp out_valid", CH), int'(ov), 1);
      repeat (7) begin
        #1;
        chk($sformatf("c%0d bp in_ready", CH), int'(ir), 0);
        chk($sformatf("c%0d bp busy", CH), int'(bz), 1);
        @(negedge clk);
      end
      ordy = 1'b1;
      #1;
      chk($sformatf("c%0d bp release in_ready", CH), int'(ir), 1);
      push(8'h53, inv_ref(8'h53));
      idle();
      drain();
      @(negedge clk);
      iv = 1'b1;
      id = 8'h37;
      #1;
      chk($sformatf("c%0d abort accept", CH), int'(ir), 1);
      @(negedge clk);
      iv = 1'b0;
      repeat (PI ? 2 : 1) @(negedge clk);
      rs = 1'b1;
      #1;
      chk($sformatf("c%0d abort busy in M1", CH), int'(bz), 1);
      @(negedge clk);
      #1;
      chk($sformatf("c%0d abort out_valid", CH), int'(ov), 0);
      chk($sformatf("c%0d abort busy", CH), int'(bz), 0);
      rs = 1'b0;
      #1;
      chk($sformatf("c%0d abort in_ready", CH), int'(ir), 1);
      send(8'hCA, inv_ref(8'hCA));
      idle();
      drain();
      repeat (3) @(negedge clk);
      done = 1'b1;
    end
  end
  initial begin
    for (int t = 0; t < 20000 && !(g_ch[0].done && g_ch[1].done); t++) @(posedge clk);
    chk("run completion", int'(g_ch[0].done && g_ch[1].done), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
